// File: rtl/mock_tss_keymask_mc.sv
// ============================================================================
// Module   : mock_tss_keymask_mc
// Brief    : LLKI key loader plus multi-lane XOR key mask with optional gating
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mock_tss_keymask_mc #(
    parameter int                       KEY_WORDS         = 2,
    parameter int                       DATA_WIDTH        = 32,
    parameter int                       NUM_LANES         = 4,
    parameter int                       GATE_UNTIL_LOADED = 1,
    parameter logic [64*KEY_WORDS-1:0]  CONST_KEY         = '0
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [63:0]                       llkid_key_data,
    input  logic                              llkid_key_valid,
    output logic                              llkid_key_ready,
    output logic                              llkid_key_complete,
    input  logic                              llkid_clear_key,
    output logic                              llkid_clear_key_ack,
    output logic                              llkid_key_error,
    input  logic [NUM_LANES*DATA_WIDTH-1:0]   in_data,
    input  logic                              in_valid,
    output logic [NUM_LANES*DATA_WIDTH-1:0]   out_data,
    output logic                              out_valid,
    output logic                              core_rst
);

    localparam int   KEY_BITS = 64 * KEY_WORDS;
    localparam int   CW       = (KEY_WORDS > 1) ? $clog2(KEY_WORDS) : 1;
    localparam int   LW       = NUM_LANES * DATA_WIDTH;
    localparam logic [CW-1:0] LAST_WORD = CW'(KEY_WORDS - 1);
    localparam bit   GATE     = (GATE_UNTIL_LOADED != 0);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LOAD     = 2'd1,
        ST_COMPLETE = 2'd2,
        ST_CLEAR    = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [KEY_BITS-1:0]   key_q, key_d;
    logic [CW-1:0]         wcnt_q, wcnt_d;
    logic                  err_q, err_d;
    logic                  complete_q;
    logic                  ack_q;
    logic [LW-1:0]         out_data_q;
    logic                  out_valid_q;
    logic [KEY_BITS-1:0]   eff_key;
    logic [LW-1:0]         lane_mask;

    // ------------------------------------------------------------------
    // Key-load FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            key_q      <= '0;
            wcnt_q     <= '0;
            err_q      <= 1'b0;
            complete_q <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            key_q      <= key_d;
            wcnt_q     <= wcnt_d;
            err_q      <= err_d;
            complete_q <= (state_d == ST_COMPLETE);
            ack_q      <= (state_d == ST_CLEAR);
        end
    end

    // ------------------------------------------------------------------
    // Key-load FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        wcnt_d  = wcnt_q;
        err_d   = err_q;
        // Clear wins over a word offered in the same cycle; while already
        // clearing, a held request is honoured again once back in idle.
        if (llkid_clear_key && (state_q != ST_CLEAR)) begin
            state_d = ST_CLEAR;
            key_d   = '0;
            wcnt_d  = '0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_LOAD: begin
                    if (llkid_key_valid) begin
                        for (int w = 0; w < KEY_WORDS; w++) begin
                            if (wcnt_q == CW'(w)) begin
                                key_d[w*64 +: 64] = llkid_key_data;
                            end
                        end
                        if (wcnt_q == LAST_WORD) begin
                            state_d = ST_COMPLETE;
                        end else begin
                            state_d = ST_LOAD;
                            wcnt_d  = wcnt_q + CW'(1);
                        end
                    end
                end
                ST_COMPLETE: begin
                    if (llkid_key_valid) begin
                        err_d = 1'b1;
                    end
                end
                ST_CLEAR: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Per-lane mask: lanes wrap around the effective key
    // ------------------------------------------------------------------
    assign eff_key = CONST_KEY ^ key_q;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        localparam int OFF = (i * DATA_WIDTH) % KEY_BITS;
        assign lane_mask[i*DATA_WIDTH +: DATA_WIDTH] = eff_key[OFF +: DATA_WIDTH];
    end

    // ------------------------------------------------------------------
    // Registered datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else if (GATE && !complete_q) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_data_q  <= in_data ^ lane_mask;
            out_valid_q <= in_valid;
        end
    end

    // ready is masked by rst so it stays low for the whole reset period
    assign llkid_key_ready     = ~rst & ((state_q == ST_IDLE) || (state_q == ST_LOAD));
    assign llkid_key_complete  = complete_q;
    assign llkid_clear_key_ack = ack_q;
    assign llkid_key_error     = err_q;
    assign out_data            = out_data_q;
    assign out_valid           = out_valid_q;
    assign core_rst            = GATE ? (rst | ~complete_q) : rst;

endmodule

`default_nettype wire
